rps_match_ctrl: RTL

Match sequencer for the rock-paper-scissors round engine. It accepts player moves over a valid/ready handshake and drives each accepted move to the round engine. It waits the engine's fixed result latency, then samples the round result, keeps the user and computer scores, and declares a best-of-N match winner. It sits between the player-input front end and the round engine and owns all match-level state.

---
 rtl/rps_match_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/rps_match_ctrl.sv
// Match sequencer for the rock-paper-scissors round engine: move handshake, result capture, scoring, best-of-N.
// Optional move-wait forfeit is built when RPS_MATCH_TIMEOUT_EN is defined.
module rps_match_ctrl #(
  parameter int unsigned ROUNDS_TO_WIN  = 2,
  parameter int unsigned MAX_ROUNDS     = 15,
  parameter int unsigned ROUND_LAT      = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       move_valid,
  input  logic [1:0] move,
  output logic       move_ready,
  output logic [1:0] eng_move,
  input  logic [1:0] eng_win,
  output logic       bad_move,
  output logic       round_done,
  output logic [1:0] round_result,
  output logic [3:0] user_score,
  output logic [3:0] cpu_score,
  output logic [4:0] round_count,
  output logic       match_done,
  output logic [1:0] match_winner
);

  localparam int unsigned SCORE_W = 4;
  localparam int unsigned CNT_W   = 5;
  localparam int unsigned LAT_W   = 3;

  typedef enum logic [2:0] {IDLE, WAIT_MOVE, WAIT_RES, SCORE, DONE} state_t;

  state_t               state, state_nxt;
  logic [1:0]           eng_move_nxt, round_result_nxt, match_winner_nxt;
  logic                 bad_move_nxt, round_done_nxt, match_done_nxt;
  logic [SCORE_W-1:0]   user_score_nxt, cpu_score_nxt, user_inc, cpu_inc;
  logic [CNT_W-1:0]     round_count_nxt, round_inc;
  logic [LAT_W-1:0]     lat_cnt, lat_cnt_nxt;

`ifdef RPS_MATCH_TIMEOUT_EN
  localparam int unsigned WAIT_W = 8;
  logic [WAIT_W-1:0]    wait_cnt, wait_cnt_nxt;
`else
  logic                 unused_cfg;
  assign unused_cfg = (TIMEOUT_CYCLES == 0);
`endif

  assign move_ready = (state == WAIT_MOVE);

  // Saturating post-increment values used by the termination check.
  assign user_inc  = (round_result == 2'b00 && user_score != '1) ? user_score + SCORE_W'(1) : user_score;
  assign cpu_inc   = (round_result == 2'b11 && cpu_score != '1) ? cpu_score + SCORE_W'(1) : cpu_score;
  assign round_inc = (round_count != '1) ? round_count + CNT_W'(1) : round_count;

  always_comb begin
    state_nxt        = state;
    eng_move_nxt     = eng_move;
    round_result_nxt = round_result;
    match_winner_nxt = match_winner;
    user_score_nxt   = user_score;
    cpu_score_nxt    = cpu_score;
    round_count_nxt  = round_count;
    match_done_nxt   = match_done;
    lat_cnt_nxt      = lat_cnt;
    bad_move_nxt     = 1'b0;
    round_done_nxt   = 1'b0;
`ifdef RPS_MATCH_TIMEOUT_EN
    wait_cnt_nxt     = '0;
`endif
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          user_score_nxt   = '0;
          cpu_score_nxt    = '0;
          round_count_nxt  = '0;
          lat_cnt_nxt      = '0;
          match_winner_nxt = 2'b01;
          match_done_nxt   = 1'b0;
          state_nxt        = WAIT_MOVE;
        end
      end
      WAIT_MOVE: begin
`ifdef RPS_MATCH_TIMEOUT_EN
        wait_cnt_nxt = wait_cnt + WAIT_W'(1);
`endif
        if (move_valid) begin
`ifdef RPS_MATCH_TIMEOUT_EN
          wait_cnt_nxt = '0;
`endif
          if (move == 2'b10) begin
            bad_move_nxt = 1'b1;
          end else begin
            eng_move_nxt = move;
            lat_cnt_nxt  = LAT_W'(ROUND_LAT);
            state_nxt    = WAIT_RES;
          end
        end
`ifdef RPS_MATCH_TIMEOUT_EN
        else if (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
          // Forfeit: the computer takes the round.
          round_result_nxt = 2'b11;
          state_nxt        = SCORE;
        end
`endif
      end
      WAIT_RES: begin
        lat_cnt_nxt = lat_cnt - LAT_W'(1);
        if (lat_cnt == LAT_W'(1)) begin
          round_result_nxt = (eng_win == 2'b10) ? 2'b01 : eng_win;
          state_nxt        = SCORE;
        end
      end
      SCORE: begin
        user_score_nxt  = user_inc;
        cpu_score_nxt   = cpu_inc;
        round_count_nxt = round_inc;
        round_done_nxt  = 1'b1;
        state_nxt       = WAIT_MOVE;
        if (user_inc == SCORE_W'(ROUNDS_TO_WIN)) begin
          match_winner_nxt = 2'b00;
          state_nxt        = DONE;
        end else if (cpu_inc == SCORE_W'(ROUNDS_TO_WIN)) begin
          match_winner_nxt = 2'b11;
          state_nxt        = DONE;
        end else if (round_inc == CNT_W'(MAX_ROUNDS)) begin
          match_winner_nxt = (user_inc > cpu_inc) ? 2'b00 :
                             (cpu_inc > user_inc) ? 2'b11 : 2'b01;
          state_nxt        = DONE;
        end
        match_done_nxt = (state_nxt == DONE);
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      eng_move     <= '0;
      bad_move     <= 1'b0;
      round_done   <= 1'b0;
      round_result <= 2'b01;
      user_score   <= '0;
      cpu_score    <= '0;
      round_count  <= '0;
      match_done   <= 1'b0;
      match_winner <= 2'b01;
      lat_cnt      <= '0;
`ifdef RPS_MATCH_TIMEOUT_EN
      wait_cnt     <= '0;
`endif
    end else begin
      state        <= state_nxt;
      eng_move     <= eng_move_nxt;
      bad_move     <= bad_move_nxt;
      round_done   <= round_done_nxt;
      round_result <= round_result_nxt;
      user_score   <= user_score_nxt;
      cpu_score    <= cpu_score_nxt;
      round_count  <= round_count_nxt;
      match_done   <= match_done_nxt;
      match_winner <= match_winner_nxt;
      lat_cnt      <= lat_cnt_nxt;
`ifdef RPS_MATCH_TIMEOUT_EN
      wait_cnt     <= wait_cnt_nxt;
`endif
    end
  end

endmodule
